addsub_checker: RTL and testbench

ADDSUB_CHECKER -- requirements
Module: addsub_checker

---
 rtl/addsub_checker_if.sv | 35 +++
 rtl/addsub_checker.sv | 167 ++++++++++++++++
 tb/tb_addsub_checker.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_checker_if.sv
// -----------------------------------------------------------------------------
// addsub_checker_if
// Handshake and result bundle between a stimulus source and addsub_checker.
//   in_valid  : source presents a vector on a, b, mode, s, c
//   in_ready  : checker can accept a vector
//   a, b      : operands driven into the adder/subtractor under check (N bits)
//   mode      : 0 = add, 1 = subtract (carry-in of the device under check)
//   s, c      : sum and carry-out returned by the device under check
//   res_valid : one-cycle pulse marking a completed check
//   res_fail  : mismatch flag for the check marked by res_valid
// Modports: master (stimulus side), slave (checker side).
// -----------------------------------------------------------------------------
interface addsub_checker_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         mode;
  logic [N-1:0] s;
  logic         c;
  logic         res_valid;
  logic         res_fail;

  modport master (
    output in_valid, a, b, mode, s, c,
    input  in_ready, res_valid, res_fail
  );

  modport slave (
    input  in_valid, a, b, mode, s, c,
    output in_ready, res_valid, res_fail
  );
endinterface

// File: rtl/addsub_checker.sv
// -----------------------------------------------------------------------------
// addsub_checker
// Checks the sum/carry returned by an N-bit adder/subtractor against a
// reference computed here. One vector is processed at a time through the
// states IDLE -> CAPT -> CMP -> RPT (one cycle each), so a result appears in
// the third cycle after the transfer edge and a new vector is accepted every
// four cycles.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : addsub_checker_if.slave (handshake, operands, result pulse)
//   pass_cnt   : saturating count of passed checks (CNT_W bits)
//   fail_cnt   : saturating count of failed checks (CNT_W bits)
//   first_fail : first failing vector {a,b,mode,s,c} since reset (3N+2 bits)
//
// Build option:
//   ADDSUB_CHK_FIRST_FAIL_EN - when defined, first_fail captures the first
//   failing vector; otherwise first_fail is constant zero and no capture
//   registers exist.
// -----------------------------------------------------------------------------
module addsub_checker #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_checker_if.slave    bus,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [3*N+1:0]     first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    CMP  = 2'd2,
    RPT  = 2'd3
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             res_fail_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;

  // Captured vector and reference result; data only, no reset needed.
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             mode_q;
  logic [N-1:0]     s_q;
  logic             c_q;
  logic [N:0]       exp_q;

  logic             xfer;
  logic [N:0]       exp_d;
  logic             mismatch_d;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // in_ready_q is high exactly in IDLE, so it doubles as the accept gate.
  assign xfer = bus.in_valid && in_ready_q;

  // Subtraction as a + ~b + 1: the carry-out is the inverted borrow, so it is
  // 1 when a >= b unsigned.
  assign exp_d = {1'b0, a_q}
               + {1'b0, (b_q ^ {N{mode_q}})}
               + {{N{1'b0}}, mode_q};

  assign mismatch_d = ({c_q, s_q} != exp_q);

  // ---- stage IDLE->CAPT: capture vector; CAPT->CMP: reference result ----
  always_ff @(posedge clk) begin
    if (xfer) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      mode_q <= bus.mode;
      s_q    <= bus.s;
      c_q    <= bus.c;
    end
    if (state_q == CAPT) begin
      exp_q <= exp_d;
    end
  end

  // ---- control FSM with registered outputs ----
  // The compare result, counter update and result pulse are all registered
  // on the CMP->RPT edge so that counters agree with res_valid/res_fail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_fail_q  <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q    <= CAPT;
            in_ready_q <= 1'b0;
          end
        end
        CAPT: begin
          state_q <= CMP;
        end
        CMP: begin
          state_q     <= RPT;
          res_valid_q <= 1'b1;
          res_fail_q  <= mismatch_d;
          if (mismatch_d) begin
            fail_cnt_q <= sat_inc(fail_cnt_q);
          end else begin
            pass_cnt_q <= sat_inc(pass_cnt_q);
          end
        end
        RPT: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
          res_fail_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
          res_fail_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_fail  = res_fail_q;
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;

`ifdef ADDSUB_CHK_FIRST_FAIL_EN
  logic [3*N+1:0] first_fail_q;
  logic           ff_seen_q;

  // ---- first-failure capture, loaded together with the failing pulse ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_q <= '0;
      ff_seen_q    <= 1'b0;
    end else if ((state_q == CMP) && mismatch_d && !ff_seen_q) begin
      first_fail_q <= {a_q, b_q, mode_q, s_q, c_q};
      ff_seen_q    <= 1'b1;
    end
  end

  assign first_fail = first_fail_q;
`else
  assign first_fail = '0;
`endif

endmodule

// File: tb/tb_addsub_checker.sv
// -----------------------------------------------------------------------------
// tb_addsub_checker
// Directed-vector bench for addsub_checker. Each scenario task drives its own
// vectors and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_addsub_checker;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [3*N+1:0]   first_fail;

  int n_checks = 0;
  int n_pass   = 0;

  addsub_checker_if #(.N(N)) bus ();

  addsub_checker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADDSUB_CHK_FIRST_FAIL_EN
  localparam logic [3*N+1:0] FF_EXP = {4'b0111, 4'b0110, 1'b1, 4'b0001, 1'b0};
`else
  localparam logic [3*N+1:0] FF_EXP = '0;
`endif

  // Presents one vector (caller is mid-cycle with the checker in IDLE) and
  // samples res_valid / in_ready 1ns after each of the next four edges, plus
  // res_fail after the third edge. Returns mid-cycle back in IDLE.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic m,
                      input logic [3:0] s, input logic c,
                      output logic [3:0] rv, output logic rf,
                      output logic [3:0] rdy);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.mode = m; bus.s = s; bus.c = c;
    rf = 1'bx;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.in_valid = 1'b0;
      rv[i]  = bus.res_valid;
      rdy[i] = bus.in_ready;
      if (i == 2) rf = bus.res_fail;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.s = '0; bus.c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if ({bus.res_valid, bus.res_fail} !== 2'b00)
      $display("FAIL reset_res: got %b expected 00", {bus.res_valid, bus.res_fail});
    else n_pass++;
    n_checks++;
    if ({pass_cnt, fail_cnt} !== 16'h0000)
      $display("FAIL reset_cnt: got %h expected 0000", {pass_cnt, fail_cnt});
    else n_pass++;
    n_checks++;
    if (first_fail !== '0) $display("FAIL reset_first_fail: got %h expected 0", first_fail);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_pass();
    logic [3:0] rv, rdy;
    logic rf;
    send(4'b0110, 4'b0110, 1'b0, 4'b1100, 1'b0, rv, rf, rdy);
    n_checks++;
    if (rv !== 4'b0100) $display("FAIL add_latency: res_valid seq got %b expected 0100", rv);
    else n_pass++;
    n_checks++;
    if (rf !== 1'b0) $display("FAIL add_res_fail: got %b expected 0", rf);
    else n_pass++;
    n_checks++;
    if (rdy !== 4'b1000) $display("FAIL add_in_ready: seq got %b expected 1000", rdy);
    else n_pass++;
    n_checks++;
    if (pass_cnt !== 8'd1) $display("FAIL add_pass_cnt: got %0d expected 1", pass_cnt);
    else n_pass++;
  endtask

  task automatic test_sub_pass();
    logic [3:0] rv, rdy;
    logic rf;
    // 6 - 6: no borrow, carry 1, sum 0
    send(4'b0110, 4'b0110, 1'b1, 4'b0000, 1'b1, rv, rf, rdy);
    n_checks++;
    if ({rv[2], rf} !== 2'b10) $display("FAIL sub_eq: valid/fail got %b expected 10", {rv[2], rf});
    else n_pass++;
    // 5 - 6: borrow, carry 0, sum 1111
    send(4'b0101, 4'b0110, 1'b1, 4'b1111, 1'b0, rv, rf, rdy);
    n_checks++;
    if ({rv[2], rf} !== 2'b10) $display("FAIL sub_borrow: valid/fail got %b expected 10", {rv[2], rf});
    else n_pass++;
    n_checks++;
    if ({pass_cnt, fail_cnt} !== {8'd3, 8'd0})
      $display("FAIL sub_cnt: got %0d/%0d expected 3/0", pass_cnt, fail_cnt);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    logic [3:0] rv, rdy;
    logic rf;
    // 7 - 6 = 1 with carry 1; device reports carry 0
    send(4'b0111, 4'b0110, 1'b1, 4'b0001, 1'b0, rv, rf, rdy);
    n_checks++;
    if ({rv[2], rf} !== 2'b11) $display("FAIL mismatch_flag: valid/fail got %b expected 11", {rv[2], rf});
    else n_pass++;
    n_checks++;
    if ({pass_cnt, fail_cnt} !== {8'd3, 8'd1})
      $display("FAIL mismatch_cnt: got %0d/%0d expected 3/1", pass_cnt, fail_cnt);
    else n_pass++;
    n_checks++;
    if (first_fail !== FF_EXP) $display("FAIL first_fail_load: got %h expected %h", first_fail, FF_EXP);
    else n_pass++;
    // A second, different failure must not overwrite the capture.
    send(4'b0000, 4'b0000, 1'b0, 4'b0011, 1'b1, rv, rf, rdy);
    n_checks++;
    if (rf !== 1'b1) $display("FAIL mismatch2_flag: got %b expected 1", rf);
    else n_pass++;
    n_checks++;
    if (first_fail !== FF_EXP) $display("FAIL first_fail_hold: got %h expected %h", first_fail, FF_EXP);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [3:0] rv, rdy;
    logic rf;
    int fails = 0;
    int valids = 0;
    int rdy_hi = 0;
    for (int a = 6; a <= 14; a++) begin
      logic [3:0] av, sv;
      av = 4'(a);
      sv = 4'(a - 6);
      send(av, 4'b0110, 1'b1, sv, 1'b1, rv, rf, rdy);
      if (rf !== 1'b0) fails++;
      for (int i = 0; i < 4; i++) begin
        if (rv[i] === 1'b1) valids++;
        if (rdy[i] === 1'b1) rdy_hi++;
      end
    end
    n_checks++;
    if (fails != 0) $display("FAIL sweep_res_fail: got %0d failures expected 0", fails);
    else n_pass++;
    n_checks++;
    if (valids != 9) $display("FAIL sweep_valids: got %0d expected 9", valids);
    else n_pass++;
    n_checks++;
    if (rdy_hi != 9) $display("FAIL sweep_in_ready: high %0d of 36 cycles expected 9", rdy_hi);
    else n_pass++;
    n_checks++;
    if ({pass_cnt, fail_cnt} !== {8'd12, 8'd2})
      $display("FAIL sweep_cnt: got %0d/%0d expected 12/2", pass_cnt, fail_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [3:0] rv, rdy;
    logic rf;
    // 260 failing vectors; fail_cnt starts at 2.
    for (int i = 0; i < 252; i++) send(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, rv, rf, rdy);
    n_checks++;
    if (fail_cnt !== 8'd254) $display("FAIL sat_pre: got %0d expected 254", fail_cnt);
    else n_pass++;
    send(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, rv, rf, rdy);
    n_checks++;
    if (fail_cnt !== 8'd255) $display("FAIL sat_reach: got %0d expected 255", fail_cnt);
    else n_pass++;
    for (int i = 0; i < 7; i++) send(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, rv, rf, rdy);
    n_checks++;
    if (fail_cnt !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", fail_cnt);
    else n_pass++;
    n_checks++;
    if (pass_cnt !== 8'd12) $display("FAIL sat_pass_unchanged: got %0d expected 12", pass_cnt);
    else n_pass++;
    // Saturated fail counter must not block pass counting.
    send(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, rv, rf, rdy);
    n_checks++;
    if ({pass_cnt, fail_cnt} !== {8'd13, 8'd255})
      $display("FAIL sat_independent: got %0d/%0d expected 13/255", pass_cnt, fail_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    logic [3:0] rv, rdy;
    logic rf;
    int seen = 0;
    bus.in_valid = 1'b1;
    bus.a = 4'b0001; bus.b = 4'b0001; bus.mode = 1'b0; bus.s = 4'b0010; bus.c = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;          // now in CMP
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL rif_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if ({pass_cnt, fail_cnt} !== 16'h0000)
      $display("FAIL rif_cnt: got %h expected 0000", {pass_cnt, fail_cnt});
    else n_pass++;
    n_checks++;
    if (first_fail !== '0) $display("FAIL rif_first_fail: got %h expected 0", first_fail);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b0) seen++;
    end
    // Present a vector before release: it must be taken on the first edge.
    bus.in_valid = 1'b1;
    bus.a = 4'b0010; bus.b = 4'b0011; bus.mode = 1'b0; bus.s = 4'b0101; bus.c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, rv, rf, rdy);
    n_checks++;
    if (seen != 0) $display("FAIL rif_no_valid: got %0d pulses expected 0", seen);
    else n_pass++;
    n_checks++;
    if ({rv, rf} !== 5'b0100_0) $display("FAIL rif_first_xfer: valid seq/fail got %b expected 01000", {rv, rf});
    else n_pass++;
    n_checks++;
    if ({pass_cnt, fail_cnt} !== {8'd1, 8'd0})
      $display("FAIL rif_cnt_after: got %0d/%0d expected 1/0", pass_cnt, fail_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_sub_pass();
    test_mismatch();
    test_sweep();
    test_saturation();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, got %0d checks expected completion", n_checks);
    $fatal(1);
  end
endmodule
